// File: rtl/rect_mask_builder.sv
// Rectangle DMA consumer. Captures a 16-value batch, then either sweeps one
// coverage plane into mask memory or copies the batch into the palette.
module rect_mask_builder #(
  parameter int X_LIMIT = 640,
  parameter int Y_LIMIT = 480,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        din,
  input  logic [2:0]         src_state,
  input  logic [3:0]         src_rect,
  input  logic [1:0]         src_batch,
  input  logic               src_batch_done,
  output logic               mask_we,
  output logic [1:0]         mask_plane,
  output logic [1:0]         mask_lane,
  output logic [COORD_W-1:0] mask_addr,
  output logic [15:0]        mask_wdata,
  output logic               pal_we,
  output logic [5:0]         pal_addr,
  output logic [15:0]        pal_wdata,
  output logic               busy,
  output logic               frame_ready,
  output logic               overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_PAL} state_t;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_LIMIT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_LIMIT - 1);

  state_t             st_q, st_d;
  logic [3:0]         prev_rect_q;
  logic               prev_done_q;
  logic [15:0]        cap_q [16];
  logic [15:0]        cap_d [16];
  logic [15:0]        swp_q [16];
  logic [15:0]        swp_d [16];
  logic [1:0]         plane_q, plane_d;
  logic [1:0]         lane_q, lane_d;
  logic [COORD_W-1:0] c_q, c_d;
  logic               overrun_q, overrun_d;
  logic               frame_q, frame_d;

  logic               mask_we_q, mask_we_d;
  logic [1:0]         mask_plane_q, mask_plane_d;
  logic [1:0]         mask_lane_q, mask_lane_d;
  logic [COORD_W-1:0] mask_addr_q, mask_addr_d;
  logic [15:0]        mask_wdata_q, mask_wdata_d;
  logic               pal_we_q, pal_we_d;
  logic [5:0]         pal_addr_q, pal_addr_d;
  logic [15:0]        pal_wdata_q, pal_wdata_d;
  logic               busy_q, busy_d;

  logic               rise;
  logic [COORD_W-1:0] last_c;
  logic [15:0]        mask_bits;

  assign rise   = src_batch_done & ~prev_done_q;
  assign last_c = plane_q[1] ? Y_LAST : X_LAST;

  always_comb begin
    cap_d     = cap_q;
    swp_d     = swp_q;
    st_d      = st_q;
    c_d       = c_q;
    plane_d   = plane_q;
    lane_d    = lane_q;
    overrun_d = overrun_q;
    frame_d   = 1'b0;
    // A rect-counter step (including the 15->0 wrap) closes the previous slot.
    if (src_state != 3'd0 && src_rect != prev_rect_q) begin
      cap_d[prev_rect_q] = din;
    end
    case (st_q)
      ST_IDLE: begin
        if (rise && src_state >= 3'd1 && src_state <= 3'd5) begin
          swp_d   = cap_q;
          plane_d = src_state[1:0] - 2'd1;
          lane_d  = src_batch;
          c_d     = '0;
          st_d    = (src_state == 3'd5) ? ST_PAL : ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (rise) overrun_d = 1'b1;
        if (c_q == last_c) st_d = ST_IDLE;
        else c_d = c_q + COORD_W'(1);
      end
      ST_PAL: begin
        if (rise) overrun_d = 1'b1;
        if (c_q[3:0] == 4'd15) begin
          st_d    = ST_IDLE;
          frame_d = (lane_q == 2'd3);
        end else begin
          c_d = c_q + COORD_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Left/top planes cover from the edge upward; right/bottom cover below it.
  for (genvar gi = 0; gi < 16; gi++) begin : g_mask
    assign mask_bits[gi] = plane_d[0] ? (c_d <  swp_d[gi][COORD_W-1:0])
                                      : (c_d >= swp_d[gi][COORD_W-1:0]);
  end

  // Output registers are loaded from next-state values so the first write
  // appears the cycle right after the batch-done rise.
  always_comb begin
    mask_we_d    = (st_d == ST_SWEEP);
    mask_plane_d = mask_we_d ? plane_d : 2'd0;
    mask_lane_d  = mask_we_d ? lane_d : 2'd0;
    mask_addr_d  = mask_we_d ? c_d : '0;
    mask_wdata_d = mask_we_d ? mask_bits : 16'd0;
    pal_we_d     = (st_d == ST_PAL);
    pal_addr_d   = pal_we_d ? {lane_d, c_d[3:0]} : 6'd0;
    pal_wdata_d  = pal_we_d ? swp_d[c_d[3:0]] : 16'd0;
    busy_d       = (st_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= ST_IDLE;
      prev_rect_q  <= 4'd0;
      prev_done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cap_q[i] <= 16'd0;
        swp_q[i] <= 16'd0;
      end
      plane_q      <= 2'd0;
      lane_q       <= 2'd0;
      c_q          <= '0;
      overrun_q    <= 1'b0;
      frame_q      <= 1'b0;
      mask_we_q    <= 1'b0;
      mask_plane_q <= 2'd0;
      mask_lane_q  <= 2'd0;
      mask_addr_q  <= '0;
      mask_wdata_q <= 16'd0;
      pal_we_q     <= 1'b0;
      pal_addr_q   <= 6'd0;
      pal_wdata_q  <= 16'd0;
      busy_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      prev_rect_q  <= src_rect;
      prev_done_q  <= src_batch_done;
      cap_q        <= cap_d;
      swp_q        <= swp_d;
      plane_q      <= plane_d;
      lane_q       <= lane_d;
      c_q          <= c_d;
      overrun_q    <= overrun_d;
      frame_q      <= frame_d;
      mask_we_q    <= mask_we_d;
      mask_plane_q <= mask_plane_d;
      mask_lane_q  <= mask_lane_d;
      mask_addr_q  <= mask_addr_d;
      mask_wdata_q <= mask_wdata_d;
      pal_we_q     <= pal_we_d;
      pal_addr_q   <= pal_addr_d;
      pal_wdata_q  <= pal_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mask_we     = mask_we_q;
  assign mask_plane  = mask_plane_q;
  assign mask_lane   = mask_lane_q;
  assign mask_addr   = mask_addr_q;
  assign mask_wdata  = mask_wdata_q;
  assign pal_we      = pal_we_q;
  assign pal_addr    = pal_addr_q;
  assign pal_wdata   = pal_wdata_q;
  assign busy        = busy_q;
  assign frame_ready = frame_q;
  assign overrun     = overrun_q;

endmodule
